// File: rtl/rr_slot_scheduler_if.sv
// -----------------------------------------------------------------------------
// rr_slot_scheduler_if
//   Bundles the request/grant signals of the round-robin slot scheduler.
//   Ports (as seen from the scheduler, modport slave):
//     req        in   N           request vector, bit i held while i wants the resource
//     grant      out  N           registered one-hot grant, all-zero when unowned
//     grant_idx  out  IW          index of the current or last owner
//     slot_count out  CW          cycles elapsed in the current tenure
//     busy       out  1           |grant
//     timeout    out  1           one-cycle pulse after a counter-ended tenure
//   Modport master is the requester side (drives req, observes the rest).
//   N and T must match the parameters of the scheduler instance.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface rr_slot_scheduler_if #(
  parameter int N = 4,
  parameter int T = 16
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (T > 1) ? $clog2(T) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic [CW-1:0] slot_count;
  logic          busy;
  logic          timeout;

  modport master (
    output req,
    input  grant, grant_idx, slot_count, busy, timeout
  );

  modport slave (
    input  req,
    output grant, grant_idx, slot_count, busy, timeout
  );
endinterface

// File: rtl/rr_slot_scheduler.sv
// -----------------------------------------------------------------------------
// rr_slot_scheduler
//   Round-robin time-slot scheduler sharing one resource among N requesters.
//   Each tenure lasts while the owner keeps requesting, up to T cycles; then
//   the owner is pre-empted and the next requester in round-robin order wins.
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    rr_slot_scheduler_if.slave (req in; grant, grant_idx, slot_count,
//            busy, timeout out)
//   Optional build macro:
//     RR_SLOT_GAP_EN - every tenure end passes through a one-cycle GAP state
//                      with the resource unowned before the next arbitration.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module rr_slot_scheduler #(
  parameter int N = 4,
  parameter int T = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_slot_scheduler_if.slave   bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic [IW-1:0] last_q, last_d;

  // Arbitration base: at a tenure end the current owner becomes "last" on the
  // same edge, so while granted the scan starts after the owner. This puts a
  // pre-empted owner at the lowest priority of the next round.
  logic [IW-1:0] base;
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan_idx;

  always_comb begin
    base     = (state_q == S_GRANT) ? idx_q : last_q;
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    // Scan from lowest to highest priority so the highest-priority hit
    // is the last one written.
    for (int k = N; k >= 1; k--) begin
      scan_idx = IW'((int'(base) + k) % N);
      if (bus.req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  logic own_req;
  logic at_max;

  assign own_req = bus.req[idx_q];
  assign at_max  = (cnt_q == CW'(T - 1));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    last_d    = last_q;

    case (state_q)
      S_GRANT: begin
        if (own_req && !at_max) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Tenure ends: release wins over a coincident counter expiry.
          last_d    = idx_q;
          timeout_d = own_req;
          cnt_d     = '0;
`ifdef RR_SLOT_GAP_EN
          grant_d   = '0;
          state_d   = S_GAP;
`else
          grant_d   = '0;
          if (win_vld) begin
            grant_d[win_idx] = 1'b1;
            idx_d            = win_idx;
            state_d          = S_GRANT;
          end else begin
            state_d          = S_IDLE;
          end
`endif
        end
      end

      default: begin
        // S_IDLE and S_GAP both arbitrate on the sampled requests.
        grant_d = '0;
        cnt_d   = '0;
        if (win_vld) begin
          grant_d[win_idx] = 1'b1;
          idx_d            = win_idx;
          state_d          = S_GRANT;
        end else begin
          state_d          = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      last_q    <= IW'(N - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_idx  = idx_q;
  assign bus.slot_count = cnt_q;
  assign bus.busy       = |grant_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_rr_slot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rr_slot_scheduler
//   Self-checking bench for rr_slot_scheduler (N=4, T=4). A cycle-level
//   reference model tracks owner, tenure length and the round-robin pointer
//   using plain integers; every cycle the DUT outputs are compared with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_slot_scheduler;

  localparam int NP = 4;
  localparam int TP = 4;

  logic clk;
  logic rst_n;

  rr_slot_scheduler_if #(.N(NP), .T(TP)) bus ();

  rr_slot_scheduler #(.N(NP), .T(TP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  int m_owner;   // -1 when the resource is unowned
  int m_idx;
  int m_cnt;
  int m_last;
  int m_to;

  task automatic model_reset();
    m_owner = -1;
    m_idx   = 0;
    m_cnt   = 0;
    m_last  = NP - 1;
    m_to    = 0;
  endtask

  function automatic int pick(input logic [NP-1:0] r, input int last);
    for (int k = 1; k <= NP; k++) begin
      int i;
      i = (last + k) % NP;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic grant_from(input logic [NP-1:0] r);
    int w;
    w = pick(r, m_last);
    m_owner = w;
    if (w >= 0) m_idx = w;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic [NP-1:0] r);
    m_to = 0;
    if (m_owner >= 0) begin
      if (r[m_owner] && m_cnt < TP - 1) begin
        m_cnt++;
      end else begin
        m_to   = r[m_owner] ? 1 : 0;
        m_last = m_owner;
`ifdef RR_SLOT_GAP_EN
        m_owner = -1;
        m_cnt   = 0;
`else
        grant_from(r);
`endif
      end
    end else begin
      grant_from(r);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("grant",      32'(bus.grant),      eg);
    chk("grant_idx",  32'(bus.grant_idx),  32'(m_idx));
    chk("slot_count", 32'(bus.slot_count), 32'(m_cnt));
    chk("busy",       32'(bus.busy),       (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("timeout",    32'(bus.timeout),    32'(m_to));
  endtask

  // Called at a negedge: drive req, let one rising edge pass, check at the
  // following negedge.
  task automatic step(input logic [NP-1:0] r);
    bus.req = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic apply_reset(input logic [NP-1:0] r);
    bus.req = r;
    rst_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] r;
    bus.req = '0;
    rst_n   = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset with all requesters active, then idle.
    apply_reset(4'b1111);
    for (int i = 0; i < 5; i++) step(4'b0000);

    // Round-robin order: each owner drops req in its third granted cycle.
    apply_reset(4'b0000);
    for (int c = 0; c < 15; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_cnt == 2) r[m_owner] = 1'b0;
      step(r);
`ifndef RR_SLOT_GAP_EN
      chk("rr_sequence", 32'(bus.grant), 32'd1 << ((c / 3) % 4));
`endif
    end

    // Pre-emption with two constant requesters.
    apply_reset(4'b0000);
    for (int c = 0; c < 12; c++) step(4'b0011);

    // Sole requester pre-emption.
    apply_reset(4'b0000);
    for (int c = 0; c < 12; c++) step(4'b0100);

    // Release coincident with the last slot: a release, not a timeout.
    apply_reset(4'b0000);
    for (int c = 0; c < 4; c++) step(4'b0011);
    chk("last_slot_cnt", 32'(bus.slot_count), 32'd3);
    step(4'b0010);
    chk("coincident_to", 32'(bus.timeout), 32'd0);
    step(4'b0010);

    // Asynchronous reset in the middle of a tenure.
    apply_reset(4'b0000);
    for (int c = 0; c < 3; c++) step(4'b0001);
    chk("pre_rst_cnt", 32'(bus.slot_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_grant", 32'(bus.grant), 32'd0);
    check_outputs();
    @(negedge clk);
    bus.req = 4'b1000;
    rst_n   = 1'b1;
    step(4'b1000);
    chk("post_rst_grant", 32'(bus.grant), 32'b1000);
    chk("post_rst_cnt",   32'(bus.slot_count), 32'd0);

    // Randomized traffic with sticky requests.
    apply_reset(4'b0000);
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      r = r ^ NP'($urandom & $urandom);
      if ($urandom_range(0, 31) == 0) r = '0;
      step(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_slot_scheduler.md
Name: rr_slot_scheduler

Overview:
- Round-robin time-slot scheduler that shares one resource among N requesters.
- An internal slot counter limits each tenure to at most T cycles.
- Sits in UTILS beside the generic counter and is the standard way to time-share a bus port, memory port or execution unit in MARVIN.
- Produces a registered one-hot grant, the winner's index, the live slot count and a pre-emption pulse.

Parameters:
- N, 4, number of requesters (N >= 2).
- T, 16, maximum tenure in clock cycles (T >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i is held high while requester i wants the resource.
- grant  output  N  one-hot grant, registered; all-zero when the resource is unowned.
- grant_idx  output  max(1,$clog2(N))  index of the current or last owner.
- slot_count  output  max(1,$clog2(T))  cycles elapsed in the current tenure; 0 in the first granted cycle.
- busy  output  1  equals |grant.
- timeout  output  1  one-cycle pulse; the previous tenure was ended by the counter, not by the requester.

Behaviour:
- Reset (async assert, sync release): grant=0, grant_idx=0, slot_count=0, busy=0, timeout=0, state=IDLE, round-robin pointer last=N-1, so requester 0 has top priority after reset.
- Asserting rst_n=0 mid-tenure clears all outputs immediately, with no waiting for a clock edge.
- Arbitration (combinational): the winner is the first i with req[i]=1, scanning (last+1) mod N upward with wrap-around.
- States:
  - IDLE, no req: stay in IDLE; outputs 0 except grant_idx, which holds.
  - IDLE, any req: at the next edge, grant[winner]=1, grant_idx=winner, slot_count=0, go to GRANT. Latency is 1 cycle from req sampled high to grant high.
  - GRANT, req[grant_idx]=1 and slot_count<T-1: slot_count increments; grant is unchanged.
  - GRANT, req[grant_idx]=0 (release): at the edge, last=grant_idx and timeout=0. If any other req is present, grant the next winner at the same edge with slot_count=0 and no bubble; otherwise grant=0 and go to IDLE.
  - GRANT, req[grant_idx]=1 and slot_count==T-1 (pre-emption): at the edge, last=grant_idx and timeout=1 for exactly one cycle. The next winner is chosen as for release. The pre-empted requester can win again only after every other active requester has had a turn. If it is the sole requester, it is re-granted immediately with slot_count=0 and timeout=1.
- Simultaneous release and slot_count==T-1 is treated as a release: timeout=0.
- Changes on req bits of non-owners are ignored until the next arbitration edge.
- T=1: every tenure lasts one cycle; timeout pulses whenever the owner is still requesting.
- Ownership rule: requester i uses the resource in exactly those cycles where grant[i]=1 and req[i]=1.
- grant is never multi-hot. slot_count never exceeds T-1 and resets to 0 at every new grant.

Optional Feature:
- Macro: RR_SLOT_GAP_EN.
- Defined: every tenure end, by release or pre-emption, enters a GAP state for exactly one cycle.
  - During GAP: grant=0, busy=0, slot_count=0; timeout behaves as without the macro.
  - The next arbitration happens at the GAP-exit edge, using req sampled in the GAP cycle.
  - A sole pre-empted requester therefore sees one idle cycle before re-grant.
- Not defined: no GAP state; back-to-back handover as described in Behaviour.

Test Plan:
- Reset and idle: rst_n=0 with req=4'b1111 -> all outputs 0. Release rst_n, req=0 for 5 cycles -> grant stays 0.
- Round-robin order: N=4, T=16, req=4'b1111, each owner drops req after 3 granted cycles then re-raises -> grant sequence 0001, 0010, 0100, 1000, 0001; 3 cycles each, no bubbles; timeout never asserts.
- Pre-emption: T=4, req=4'b0011 held constant -> grant 0001 for 4 cycles (slot_count 0..3), then 0010 with timeout=1 for one cycle, then 0001 again.
- Sole requester pre-emption: T=4, req=4'b0100 constant -> grant stays 0100, slot_count wraps 3 to 0, and timeout pulses every 4th cycle. With RR_SLOT_GAP_EN, grant=0 for one cycle between tenures.
- Simultaneous events: T=4, owner drops req in its slot_count==3 cycle while another requester is active -> handover with timeout=0.
- Async reset mid-tenure: pull rst_n low between edges at slot_count=2 -> grant=0 immediately. After release with req=4'b1000 -> requester 3 is granted one cycle later with slot_count=0.
